// File: rtl/cart_mem_arbiter_if.sv
// Signal bundle between the CPU/PPU requesters, the cartridge memory and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface cart_mem_arbiter_if;
  logic        cart_ready;

  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_ram_sel;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  logic        ppu_req;
  logic        ppu_we;
  logic [20:0] ppu_addr;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;
  logic        ppu_ack;

  logic [20:0] mem_address;
  logic        mem_prg_sel;
  logic        mem_chr_sel;
  logic        mem_ram_sel;
  logic        mem_rden;
  logic        mem_wren;
  logic [7:0]  mem_write_data;
  logic [7:0]  mem_read_data;

  logic        busy;

  modport slave (
    input  cart_ready,
    input  cpu_req, cpu_we, cpu_ram_sel, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  ppu_req, ppu_we, ppu_addr, ppu_wdata,
    output ppu_rdata, ppu_ack,
    output mem_address, mem_prg_sel, mem_chr_sel, mem_ram_sel,
    output mem_rden, mem_wren, mem_write_data,
    input  mem_read_data,
    output busy
  );

  modport master (
    output cart_ready,
    output cpu_req, cpu_we, cpu_ram_sel, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output ppu_req, ppu_we, ppu_addr, ppu_wdata,
    input  ppu_rdata, ppu_ack,
    input  mem_address, mem_prg_sel, mem_chr_sel, mem_ram_sel,
    input  mem_rden, mem_wren, mem_write_data,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/cart_mem_arbiter.sv
// Shares the single-ported cartridge memory between CPU and PPU: PPU priority,
// bounded CPU starvation, fixed ISSUE/WAIT/DONE sequence per access.
module cart_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset_n,
  cart_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_ownerPpu;
  logic        r_we;
  logic [3:0]  r_starveCnt;
  logic [20:0] r_memAddress;
  logic        r_prgSel;
  logic        r_chrSel;
  logic        r_ramSel;
  logic        r_rden;
  logic        r_wren;
  logic [7:0]  r_wdata;
  logic [7:0]  r_cpuRdata;
  logic [7:0]  r_ppuRdata;
  logic        r_cpuAck;
  logic        r_ppuAck;

  logic        w_arbitrate;
  logic        w_cpuElig;
  logic        w_ppuElig;
  logic        w_grantCpu;
  logic        w_grantPpu;

  // DONE arbitrates like IDLE; a port whose ack is high this cycle sits out.
  always_comb begin
    w_arbitrate = (r_state == ST_IDLE) || (r_state == ST_DONE);
    w_cpuElig   = bus.cpu_req && !r_cpuAck;
    w_ppuElig   = bus.ppu_req && !r_ppuAck;
    w_grantCpu  = 1'b0;
    w_grantPpu  = 1'b0;
    w_nextState = r_state;

    if (w_arbitrate && bus.cart_ready) begin
      if (w_cpuElig && w_ppuElig) begin
        if (r_starveCnt == LP_LIMIT) begin
          w_grantCpu = 1'b1;
        end else begin
          w_grantPpu = 1'b1;
        end
      end else if (w_cpuElig) begin
        w_grantCpu = 1'b1;
      end else if (w_ppuElig) begin
        w_grantPpu = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE, ST_DONE: w_nextState = (w_grantCpu || w_grantPpu) ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:         w_nextState = ST_WAIT;
      ST_WAIT:          w_nextState = ST_DONE;
      default:          w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ownerPpu   <= 1'b0;
      r_we         <= 1'b0;
      r_memAddress <= '0;
      r_prgSel     <= 1'b0;
      r_chrSel     <= 1'b0;
      r_ramSel     <= 1'b0;
      r_rden       <= 1'b0;
      r_wren       <= 1'b0;
      r_wdata      <= '0;
      r_cpuRdata   <= '0;
      r_ppuRdata   <= '0;
      r_cpuAck     <= 1'b0;
      r_ppuAck     <= 1'b0;
    end else begin
      r_rden   <= 1'b0;
      r_wren   <= 1'b0;
      r_wdata  <= '0;
      r_cpuAck <= 1'b0;
      r_ppuAck <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_grantCpu) begin
            r_ownerPpu   <= 1'b0;
            r_we         <= bus.cpu_we;
            r_memAddress <= bus.cpu_addr;
            r_prgSel     <= !bus.cpu_ram_sel;
            r_chrSel     <= 1'b0;
            r_ramSel     <= bus.cpu_ram_sel;
            r_rden       <= !bus.cpu_we;
            r_wren       <= bus.cpu_we;
            r_wdata      <= bus.cpu_wdata;
          end else if (w_grantPpu) begin
            r_ownerPpu   <= 1'b1;
            r_we         <= bus.ppu_we;
            r_memAddress <= bus.ppu_addr;
            r_prgSel     <= 1'b0;
            r_chrSel     <= 1'b1;
            r_ramSel     <= 1'b0;
            r_rden       <= !bus.ppu_we;
            r_wren       <= bus.ppu_we;
            r_wdata      <= bus.ppu_wdata;
          end else begin
            r_memAddress <= '0;
            r_prgSel     <= 1'b0;
            r_chrSel     <= 1'b0;
            r_ramSel     <= 1'b0;
          end
        end
        ST_WAIT: begin
          r_memAddress <= '0;
          r_prgSel     <= 1'b0;
          r_chrSel     <= 1'b0;
          r_ramSel     <= 1'b0;
          if (r_ownerPpu) begin
            r_ppuAck <= 1'b1;
            if (!r_we) begin
              r_ppuRdata <= bus.mem_read_data;
            end
          end else begin
            r_cpuAck <= 1'b1;
            if (!r_we) begin
              r_cpuRdata <= bus.mem_read_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Counts PPU wins that overtook a waiting CPU; saturates so the CPU wins next time both compete.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starveCnt <= '0;
    end else if (w_grantCpu) begin
      r_starveCnt <= '0;
    end else if (w_grantPpu && bus.cpu_req) begin
      if (r_starveCnt < LP_LIMIT) begin
        r_starveCnt <= r_starveCnt + 4'd1;
      end
    end else if (w_arbitrate && !bus.cpu_req) begin
      r_starveCnt <= '0;
    end
  end

  assign bus.mem_address    = r_memAddress;
  assign bus.mem_prg_sel    = r_prgSel;
  assign bus.mem_chr_sel    = r_chrSel;
  assign bus.mem_ram_sel    = r_ramSel;
  assign bus.mem_rden       = r_rden;
  assign bus.mem_wren       = r_wren;
  assign bus.mem_write_data = r_wdata;
  assign bus.cpu_rdata      = r_cpuRdata;
  assign bus.cpu_ack        = r_cpuAck;
  assign bus.ppu_rdata      = r_ppuRdata;
  assign bus.ppu_ack        = r_ppuAck;
  assign bus.busy           = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios, then random traffic scored against a
// transaction-level model that schedules each grant's ISSUE/WAIT/DONE cycles.
module tb_cart_mem_arbiter;

  localparam int LIMIT       = 4;
  localparam int RAND_CYCLES = 3000;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] memArr [logic [22:0]];

  cart_mem_arbiter_if bus_if ();

  cart_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] memDefault(input logic [22:0] key);
    return key[7:0] ^ key[15:8] ^ {1'b0, key[22:16]} ^ 8'h5A;
  endfunction

  // Cartridge model: region keyed storage, read data one cycle after mem_rden.
  always @(posedge clock) begin : memModel
    logic [22:0] key;
    key = {(bus_if.mem_ram_sel ? 2'd2 : (bus_if.mem_chr_sel ? 2'd1 : 2'd0)), bus_if.mem_address};
    if (bus_if.mem_wren) memArr[key] = bus_if.mem_write_data;
    if (bus_if.mem_rden) bus_if.mem_read_data <= memArr.exists(key) ? memArr[key] : memDefault(key);
  end

  function automatic logic [52:0] allOut();
    return {bus_if.mem_address, bus_if.mem_prg_sel, bus_if.mem_chr_sel, bus_if.mem_ram_sel,
            bus_if.mem_rden, bus_if.mem_wren, bus_if.mem_write_data, bus_if.cpu_rdata,
            bus_if.cpu_ack, bus_if.ppu_rdata, bus_if.ppu_ack, bus_if.busy};
  endfunction

  function automatic logic [4:0] selStrobe();
    return {bus_if.mem_prg_sel, bus_if.mem_chr_sel, bus_if.mem_ram_sel, bus_if.mem_rden, bus_if.mem_wren};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    bus_if.cart_ready  = 1'b1;
    bus_if.cpu_req     = 1'b0;
    bus_if.cpu_we      = 1'b0;
    bus_if.cpu_ram_sel = 1'b0;
    bus_if.cpu_addr    = '0;
    bus_if.cpu_wdata   = '0;
    bus_if.ppu_req     = 1'b0;
    bus_if.ppu_we      = 1'b0;
    bus_if.ppu_addr    = '0;
    bus_if.ppu_wdata   = '0;
  endtask

  task automatic randCpuFields();
    logic [31:0] r;
    r = $urandom;
    bus_if.cpu_we      = r[0];
    bus_if.cpu_ram_sel = r[1];
    bus_if.cpu_addr    = r[2] ? 21'(r[6:3]) : r[28:8];
    bus_if.cpu_wdata   = 8'($urandom);
  endtask

  task automatic randPpuFields();
    logic [31:0] r;
    r = $urandom;
    bus_if.ppu_we    = r[0];
    bus_if.ppu_addr  = r[2] ? 21'(r[6:3]) : r[28:8];
    bus_if.ppu_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clearInputs();
    repeat (2) step();
    checks++;
    if (allOut() !== 53'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, want 0", allOut());
    end
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (allOut() !== 53'h0) begin
      errors++;
      $display("[TB] FAIL reset_idle_after_release: got %h, want 0", allOut());
    end
  endtask

  task automatic test_cpu_read();
    int acks;
    memArr[{2'd0, 21'h00123}] = 8'hA5;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 21'h00123;
    step();
    checks++;
    if (selStrobe() !== 5'b10010 || bus_if.mem_address !== 21'h00123 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cpu_read_issue: got sel/strobe=%b addr=%h busy=%b, want 10010 00123 1",
               selStrobe(), bus_if.mem_address, bus_if.busy);
    end
    step();
    checks++;
    if (selStrobe() !== 5'b10000 || bus_if.mem_address !== 21'h00123 || bus_if.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cpu_read_wait: got sel/strobe=%b addr=%h busy=%b, want 10000 00123 1",
               selStrobe(), bus_if.mem_address, bus_if.busy);
    end
    step();
    checks++;
    if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== 8'hA5 || bus_if.ppu_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_ack: got ack=%b rdata=%h ppu_ack=%b, want 1 a5 0",
               bus_if.cpu_ack, bus_if.cpu_rdata, bus_if.ppu_ack);
    end
    checks++;
    if (selStrobe() !== 5'b0 || bus_if.mem_address !== 21'h0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cpu_read_done_bus: got sel/strobe=%b addr=%h busy=%b, want 0 0 0",
               selStrobe(), bus_if.mem_address, bus_if.busy);
    end
    bus_if.cpu_req = 1'b0;
    acks = 0;
    repeat (4) begin
      step();
      if (bus_if.cpu_ack) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("[TB] FAIL cpu_read_single_ack: got %0d extra acks, want 0", acks);
    end
  endtask

  task automatic test_cpu_write();
    bus_if.cpu_req     = 1'b1;
    bus_if.cpu_we      = 1'b1;
    bus_if.cpu_ram_sel = 1'b1;
    bus_if.cpu_addr    = 21'h01FFF;
    bus_if.cpu_wdata   = 8'h3C;
    step();
    checks++;
    if (selStrobe() !== 5'b00101 || bus_if.mem_write_data !== 8'h3C || bus_if.mem_address !== 21'h01FFF) begin
      errors++;
      $display("[TB] FAIL cpu_write_issue: got sel/strobe=%b wdata=%h addr=%h, want 00101 3c 01fff",
               selStrobe(), bus_if.mem_write_data, bus_if.mem_address);
    end
    step();
    checks++;
    if (selStrobe() !== 5'b00100 || bus_if.mem_address !== 21'h01FFF) begin
      errors++;
      $display("[TB] FAIL cpu_write_wait: got sel/strobe=%b addr=%h, want 00100 01fff",
               selStrobe(), bus_if.mem_address);
    end
    step();
    checks++;
    if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_rdata !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL cpu_write_ack: got ack=%b rdata=%h, want 1 a5", bus_if.cpu_ack, bus_if.cpu_rdata);
    end
    checks++;
    if (!memArr.exists({2'd2, 21'h01FFF}) || memArr[{2'd2, 21'h01FFF}] !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL cpu_write_stored: sram[01fff] not 3c");
    end
    clearInputs();
    repeat (2) step();
  endtask

  task automatic test_simultaneous();
    logic [4:0] expSel [1:6];
    logic [1:0] expAck [1:6];
    expSel = '{5'b01010, 5'b01000, 5'b00000, 5'b10010, 5'b10000, 5'b00000};
    expAck = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    memArr.delete();
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 21'h00200;
    bus_if.ppu_req  = 1'b1;
    bus_if.ppu_addr = 21'h00040;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (selStrobe() !== expSel[c] || {bus_if.cpu_ack, bus_if.ppu_ack} !== expAck[c]) begin
        errors++;
        $display("[TB] FAIL simul_cycle%0d: got sel/strobe=%b acks=%b, want %b %b",
                 c, selStrobe(), {bus_if.cpu_ack, bus_if.ppu_ack}, expSel[c], expAck[c]);
      end
      if (bus_if.ppu_ack) begin
        bus_if.ppu_req = 1'b0;
        checks++;
        if (bus_if.ppu_rdata !== memDefault({2'd1, 21'h00040})) begin
          errors++;
          $display("[TB] FAIL simul_ppu_rdata: got %h, want %h", bus_if.ppu_rdata, memDefault({2'd1, 21'h00040}));
        end
      end
      if (bus_if.cpu_ack) begin
        bus_if.cpu_req = 1'b0;
        checks++;
        if (bus_if.cpu_rdata !== memDefault({2'd0, 21'h00200})) begin
          errors++;
          $display("[TB] FAIL simul_cpu_rdata: got %h, want %h", bus_if.cpu_rdata, memDefault({2'd0, 21'h00200}));
        end
      end
    end
    clearInputs();
    repeat (2) step();
  endtask

  task automatic test_cart_ready();
    int seen;
    int cpuAcks;
    int ppuAcks;
    bus_if.cart_ready = 1'b0;
    bus_if.cpu_req    = 1'b1;
    bus_if.cpu_addr   = 21'h00010;
    bus_if.ppu_req    = 1'b1;
    bus_if.ppu_addr   = 21'h00020;
    seen = 0;
    repeat (20) begin
      step();
      if (bus_if.mem_rden || bus_if.mem_wren || bus_if.cpu_ack || bus_if.ppu_ack || bus_if.busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL cart_ready_gating: got %0d active cycles, want 0", seen);
    end
    bus_if.cart_ready = 1'b1;
    step();
    checks++;
    if (selStrobe() !== 5'b01010) begin
      errors++;
      $display("[TB] FAIL cart_ready_ppu_first: got sel/strobe=%b, want 01010", selStrobe());
    end
    cpuAcks = 0;
    ppuAcks = 0;
    repeat (12) begin
      step();
      if (bus_if.ppu_ack) begin ppuAcks++; bus_if.ppu_req = 1'b0; end
      if (bus_if.cpu_ack) begin cpuAcks++; bus_if.cpu_req = 1'b0; end
    end
    checks++;
    if (cpuAcks != 1 || ppuAcks != 1) begin
      errors++;
      $display("[TB] FAIL cart_ready_drain: got cpu acks=%0d ppu acks=%0d, want 1 1", cpuAcks, ppuAcks);
    end
    clearInputs();
    repeat (2) step();
  endtask

  task automatic test_starvation();
    logic [1:0] expAck;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 21'h00300;
    bus_if.ppu_req  = 1'b1;
    bus_if.ppu_addr = 21'h00400;
    for (int it = 0; it < 6; it++) begin
      bus_if.cart_ready = 1'b1;
      step();
      bus_if.cart_ready = 1'b0;
      step();
      step();
      expAck = (it == LIMIT) ? 2'b10 : 2'b01;
      checks++;
      if ({bus_if.cpu_ack, bus_if.ppu_ack} !== expAck) begin
        errors++;
        $display("[TB] FAIL starve_grant%0d: got acks=%b, want %b", it, {bus_if.cpu_ack, bus_if.ppu_ack}, expAck);
      end
      if (bus_if.cpu_ack) bus_if.cpu_req = 1'b0;
      step();
    end
    clearInputs();
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    int seen;
    memArr[{2'd0, 21'h00777}] = 8'h77;
    bus_if.cpu_req  = 1'b1;
    bus_if.cpu_addr = 21'h00777;
    step();
    step();
    reset_n        = 1'b0;
    bus_if.cpu_req = 1'b0;
    #1;
    checks++;
    if (allOut() !== 53'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async: got %h, want 0", allOut());
    end
    step();
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      step();
      if (allOut() !== 53'h0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle_after: got %0d non-idle cycles, want 0", seen);
    end
  endtask

  task automatic test_random();
    int          lastG;
    int          d;
    int          starve;
    logic        gPpu;
    logic        gWe;
    logic [1:0]  gRegion;
    logic [20:0] gAddr;
    logic [7:0]  gWdata;
    logic [7:0]  gData;
    logic [7:0]  expCpuRdata;
    logic [7:0]  expPpuRdata;
    logic [33:0] expMem;
    logic [33:0] gotMem;
    logic [2:0]  expCtl;
    logic [2:0]  gotCtl;
    logic        inFlight;
    logic        cpuAckNow;
    logic        ppuAckNow;
    logic        cpuE;
    logic        ppuE;
    logic        grantCpu;
    logic        grantPpu;
    logic [22:0] key;
    logic [7:0]  shadow [logic [22:0]];

    memArr.delete();
    lastG = -100;
    starve = 0;
    gPpu = 1'b0; gWe = 1'b0; gRegion = 2'd0; gAddr = '0; gWdata = '0; gData = '0;
    expCpuRdata = 8'h00;
    expPpuRdata = 8'h00;
    clearInputs();

    for (int k = 0; k < RAND_CYCLES; k++) begin
      d = k - lastG;
      inFlight = (d == 1) || (d == 2);
      if (d == 3 && !gWe) begin
        if (gPpu) expPpuRdata = gData;
        else      expCpuRdata = gData;
      end
      cpuAckNow = (d == 3) && !gPpu;
      ppuAckNow = (d == 3) && gPpu;

      expMem = {inFlight ? gAddr : 21'h0, inFlight && gRegion == 2'd0, inFlight && gRegion == 2'd1,
                inFlight && gRegion == 2'd2, d == 1 && !gWe, d == 1 && gWe, (d == 1) ? gWdata : 8'h00};
      gotMem = {bus_if.mem_address, selStrobe(), bus_if.mem_write_data};
      checks++;
      if (gotMem !== expMem) begin
        errors++;
        $display("[TB] FAIL rand_mem cycle %0d: got %h, want %h", k, gotMem, expMem);
      end
      expCtl = {cpuAckNow, ppuAckNow, inFlight};
      gotCtl = {bus_if.cpu_ack, bus_if.ppu_ack, bus_if.busy};
      checks++;
      if (gotCtl !== expCtl) begin
        errors++;
        $display("[TB] FAIL rand_ack_busy cycle %0d: got %b, want %b", k, gotCtl, expCtl);
      end
      checks++;
      if ({bus_if.cpu_rdata, bus_if.ppu_rdata} !== {expCpuRdata, expPpuRdata}) begin
        errors++;
        $display("[TB] FAIL rand_rdata cycle %0d: got %h/%h, want %h/%h",
                 k, bus_if.cpu_rdata, bus_if.ppu_rdata, expCpuRdata, expPpuRdata);
      end

      if (bus_if.cpu_req) begin
        if (cpuAckNow) begin
          if ($urandom_range(0, 1) == 0) bus_if.cpu_req = 1'b0;
          else randCpuFields();
        end else if ($urandom_range(0, 31) == 0) begin
          bus_if.cpu_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus_if.cpu_req = 1'b1;
        randCpuFields();
      end
      if (bus_if.ppu_req) begin
        if (ppuAckNow) begin
          if ($urandom_range(0, 1) == 0) bus_if.ppu_req = 1'b0;
          else randPpuFields();
        end else if ($urandom_range(0, 31) == 0) begin
          bus_if.ppu_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus_if.ppu_req = 1'b1;
        randPpuFields();
      end
      bus_if.cart_ready = ($urandom_range(0, 5) != 0);

      if (d >= 3) begin
        cpuE = bus_if.cpu_req && !cpuAckNow;
        ppuE = bus_if.ppu_req && !ppuAckNow;
        grantCpu = 1'b0;
        grantPpu = 1'b0;
        if (bus_if.cart_ready) begin
          if (cpuE && ppuE) begin
            if (starve == LIMIT) grantCpu = 1'b1;
            else                 grantPpu = 1'b1;
          end else if (cpuE) begin
            grantCpu = 1'b1;
          end else if (ppuE) begin
            grantPpu = 1'b1;
          end
        end
        if (grantCpu) starve = 0;
        else if (grantPpu && bus_if.cpu_req) starve = (starve < LIMIT) ? starve + 1 : starve;
        else if (!bus_if.cpu_req) starve = 0;

        if (grantCpu || grantPpu) begin
          lastG = k;
          gPpu  = grantPpu;
          if (grantPpu) begin
            gWe = bus_if.ppu_we; gAddr = bus_if.ppu_addr; gWdata = bus_if.ppu_wdata; gRegion = 2'd1;
          end else begin
            gWe = bus_if.cpu_we; gAddr = bus_if.cpu_addr; gWdata = bus_if.cpu_wdata;
            gRegion = bus_if.cpu_ram_sel ? 2'd2 : 2'd0;
          end
          key = {gRegion, gAddr};
          if (gWe) shadow[key] = gWdata;
          else     gData = shadow.exists(key) ? shadow[key] : memDefault(key);
        end
      end
      step();
    end
    clearInputs();
    repeat (5) step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_simultaneous();
    test_cart_ready();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
